// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
//   mem_state_e : controller FSM states (idle, low half, high half, done)
//   mem_op_e    : latched operation (load or store)
//   SRAM_DW     : SRAM data width
//   DEF_*       : default wait cycles per half access and SRAM base byte address
//   WAIT_CNT_W  : width of the per-phase wait counter
package mem_ctrl_pkg;

  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_ADDR_BASE   = 1024;
  localparam int unsigned WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } mem_state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing one SRAM half-access phase.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : reload with i_load_val (takes priority over i_en)
//   i_load_val   : phase length in cycles
//   i_en         : count down by one (saturates at zero)
//   o_count      : current count; runs i_load_val .. 1 across a phase
//   o_last       : high on the final cycle of the phase (count == 1)
module mem_wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_load_val,
  input  logic                  i_en,
  output logic [WAIT_CNT_W-1:0] o_count,
  output logic                  o_last
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WAIT_CNT_W'(1);
    end
  end

  assign o_count = r_cnt;
  assign o_last  = (r_cnt == WAIT_CNT_W'(1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller between the EX/MEM register and a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half-word accesses (low, then high), each
// WAIT_CYCLES (1..15) long. o_ready low freezes the pipeline while an access runs.
// Ports:
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_mem_r_en, i_mem_w_en : load / store request, held while o_ready is low
//   i_addr, i_wdata        : byte address and store data
//   o_rdata                : registered load data
//   o_ready                : 1 = MEM stage may advance
//   o_sram_addr            : SRAM half-word address, bit 0 selects the half
//   o_sram_we_n            : SRAM write strobe, active low
//   o_sram_dq_out/_oe      : pad write data and output enable
//   i_sram_dq_in           : pad read data
// Optional build macro MEM_CTRL_STATS_EN adds o_rd_cnt, o_wr_cnt, o_stall_cnt.
module mem_stage_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mem_r_en,
  input  logic               i_mem_w_en,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic               o_sram_we_n,
  output logic [SRAM_DW-1:0] o_sram_dq_out,
  output logic               o_sram_dq_oe,
  input  logic [SRAM_DW-1:0] i_sram_dq_in
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [31:0]        o_rd_cnt,
  output logic [31:0]        o_wr_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int unsigned           WordW    = SRAM_AW - 1;
  localparam logic [WAIT_CNT_W-1:0] WaitLoad = WAIT_CNT_W'(WAIT_CYCLES);

  mem_state_e            r_state;
  mem_op_e               r_op;
  logic [WordW-1:0]      r_word;
  logic [SRAM_DW-1:0]    r_wdata_hi;
  logic [31:0]           r_rdata;
  logic [SRAM_AW-1:0]    r_sram_addr;
  logic                  r_sram_we_n;
  logic [SRAM_DW-1:0]    r_sram_dq_out;
  logic                  r_sram_dq_oe;

  logic                  w_req;
  mem_op_e               w_op;
  logic [31:0]           w_off;
  logic [WordW-1:0]      w_word;
  logic                  w_unused_off;
  logic                  w_is_wr;
  logic                  w_we_n_next;
  logic                  w_cnt_load;
  logic                  w_cnt_en;
  logic                  w_last;
  logic [WAIT_CNT_W-1:0] w_count;

  assign w_req  = i_mem_r_en | i_mem_w_en;
  // A simultaneous load and store request is served as a store.
  assign w_op   = i_mem_w_en ? OpWr : OpRd;
  // Word index wraps modulo the SRAM word count.
  assign w_off  = i_addr - 32'(ADDR_BASE);
  assign w_word = w_off[WordW+1:2];
  assign w_unused_off = ^{w_off[31:WordW+2], w_off[1:0]};

  assign w_is_wr = (r_op == OpWr);
  // Strobe rises one cycle before a multi-cycle write phase ends (hold margin);
  // count 2 now means the next cycle is the last one of the phase.
  assign w_we_n_next = !w_is_wr || (w_count == WAIT_CNT_W'(2));

  assign w_cnt_load = ((r_state == StIdle) && w_req) || ((r_state == StLo) && w_last);
  assign w_cnt_en   = (r_state == StLo) || (r_state == StHi);

  mem_wait_counter u_wait (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (WaitLoad),
    .i_en       (w_cnt_en),
    .o_count    (w_count),
    .o_last     (w_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_op          <= OpRd;
      r_word        <= '0;
      r_wdata_hi    <= '0;
      r_rdata       <= '0;
      r_sram_addr   <= '0;
      r_sram_we_n   <= 1'b1;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_state       <= StLo;
            r_op          <= w_op;
            r_word        <= w_word;
            r_wdata_hi    <= i_wdata[31:16];
            r_sram_addr   <= {w_word, 1'b0};
            r_sram_dq_out <= i_wdata[15:0];
            r_sram_dq_oe  <= (w_op == OpWr);
            r_sram_we_n   <= (w_op != OpWr);
          end
        end
        StLo: begin
          if (w_last) begin
            if (!w_is_wr) begin
              r_rdata[15:0] <= i_sram_dq_in;
            end
            r_state       <= StHi;
            r_sram_addr   <= {r_word, 1'b1};
            r_sram_dq_out <= r_wdata_hi;
            r_sram_we_n   <= !w_is_wr;
          end else begin
            r_sram_we_n <= w_we_n_next;
          end
        end
        StHi: begin
          if (w_last) begin
            if (!w_is_wr) begin
              r_rdata[31:16] <= i_sram_dq_in;
            end
            r_state      <= StDone;
            r_sram_we_n  <= 1'b1;
            r_sram_dq_oe <= 1'b0;
          end else begin
            r_sram_we_n <= w_we_n_next;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ready       = ((r_state == StIdle) && !w_req) || (r_state == StDone);
  assign o_rdata       = r_rdata;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_we_n   = r_sram_we_n;
  assign o_sram_dq_out = r_sram_dq_out;
  assign o_sram_dq_oe  = r_sram_dq_oe;

`ifdef MEM_CTRL_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_enter_done;

  assign w_enter_done = (r_state == StHi) && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_enter_done && !w_is_wr) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (w_enter_done && w_is_wr) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
      if (!o_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_rd_cnt    = r_rd_cnt;
  assign o_wr_cnt    = r_wr_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
